down_timer: RTL and testbench



---
 rtl/down_timer_if.sv | 36 +++
 rtl/down_timer.sv | 92 +++++++++
 tb/tb_down_timer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/down_timer_if.sv
// down_timer control/status bundle.
// Master drives the controls; the timer (slave) returns its status.
interface down_timer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             reload_en;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             expire;

  modport master (
    output start,
    output load_value,
    output enable,
    output reload_en,
    output abort,
    input  count,
    input  busy,
    input  expire
  );

  modport slave (
    input  start,
    input  load_value,
    input  enable,
    input  reload_en,
    input  abort,
    output count,
    output busy,
    output expire
  );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer: one-shot or auto-reload,
// abort/restart, registered one-cycle terminal-count pulse.
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  down_timer_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expire_q, expire_d;

  // State, count, reload value and expire pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      expire_q <= expire_d;
    end
  end

  // Next state: abort beats start, start beats enable.
  // A zero load fires expire at once and never enters RUN.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    expire_d = 1'b0;
    if (bus.abort) begin
      if (state_q == RUN) begin
        count_d = ZERO;
        state_d = IDLE;
      end
    end else if (bus.start) begin
      if (bus.load_value != ZERO) begin
        count_d  = bus.load_value;
        reload_d = bus.load_value;
        state_d  = RUN;
      end else begin
        count_d  = ZERO;
        expire_d = 1'b1;
        state_d  = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        RUN: begin
          if (bus.enable) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else begin
              expire_d = 1'b1;
              if (bus.reload_en) begin
                count_d = reload_q;
              end else begin
                count_d = ZERO;
                state_d = IDLE;
              end
            end
          end
        end
        default: begin
          count_d = ZERO;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.count  = count_q;
  assign bus.busy   = (state_q == RUN);
  assign bus.expire = expire_q;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus
// random traffic, compared cycle by cycle with a reference model.
module tb_down_timer;

  localparam int W = 8;

  logic clock;
  logic reset;

  down_timer_if #(.WIDTH(W)) bus ();

  down_timer #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors;
  int checks;

  // reference model state
  int m_cnt;
  int m_rel;
  bit m_run;
  bit m_exp;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_rel = 0;
    m_run = 0;
    m_exp = 0;
  endtask

  // One clock of timer behaviour, from the rules in plain terms.
  task automatic model_step(input bit st, input int lv, input bit en,
                            input bit rl, input bit ab);
    bit e;
    e = 0;
    if (ab) begin
      if (m_run) begin
        m_cnt = 0;
        m_run = 0;
      end
    end else if (st) begin
      if (lv == 0) begin
        e     = 1;
        m_cnt = 0;
        m_run = 0;
      end else begin
        m_cnt = lv;
        m_rel = lv;
        m_run = 1;
      end
    end else if (m_run && en) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        e = 1;
        if (rl) m_cnt = m_rel;
        else m_run = 0;
      end
    end
    m_exp = e;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".count"},  32'(bus.count),  32'(m_cnt));
    chk({tag, ".busy"},   32'(bus.busy),   32'(m_run));
    chk({tag, ".expire"}, 32'(bus.expire), 32'(m_exp));
  endtask

  task automatic cyc(input bit st, input int lv, input bit en,
                     input bit rl, input bit ab, input string tag);
    @(negedge clock);
    bus.start      = st;
    bus.load_value = W'(lv);
    bus.enable     = en;
    bus.reload_en  = rl;
    bus.abort      = ab;
    @(posedge clock);
    model_step(st, lv, en, rl, ab);
    #1;
    check_outputs(tag);
  endtask

  // Reset asserted between edges; outputs must clear before any edge.
  task automatic areset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  int lat;
  bit st_r, en_r, rl_r, ab_r;
  int lv_r;

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.start      = 1'b0;
    bus.load_value = '0;
    bus.enable     = 1'b0;
    bus.reload_en  = 1'b0;
    bus.abort      = 1'b0;
    model_reset();
    #1;
    check_outputs("por");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // one-shot N=3
    cyc(1, 3, 1, 0, 0, "os3_start");
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, "os3_run");
    chk("os3_end_busy", 32'(bus.busy), 32'd0);

    // auto-reload N=2, then drop reload_en
    cyc(1, 2, 1, 1, 0, "ar2_start");
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 1, 0, "ar2_run");
      if (bus.expire === 1'b1) lat++;
    end
    chk("ar2_pulses", 32'(lat), 32'd4);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 0, "ar2_stop");

    // auto-reload N=1: continuous pulses
    cyc(1, 1, 1, 1, 0, "ar1_start");
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, "ar1_run");
    cyc(0, 0, 1, 0, 0, "ar1_stop");
    cyc(0, 0, 1, 0, 0, "ar1_idle");

    // enable gap: expire 7 edges after start
    cyc(1, 4, 1, 0, 0, "gap_start");
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      cyc(0, 0, !(i >= 2 && i <= 4), 0, 0, "gap_run");
      if (bus.expire === 1'b1) lat = i;
    end
    chk("gap_latency", 32'(lat), 32'd7);

    // abort at count=1
    cyc(1, 5, 1, 0, 0, "ab_start");
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, "ab_run");
    chk("ab_at1", 32'(bus.count), 32'd1);
    cyc(0, 0, 1, 0, 1, "ab_abort");
    cyc(0, 0, 1, 0, 0, "ab_after");

    // restart with 2 at count=3
    cyc(1, 5, 1, 0, 0, "rs_start");
    for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 0, "rs_run");
    cyc(1, 2, 1, 0, 0, "rs_restart");
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, "rs_run2");

    // zero load in IDLE and in RUN
    cyc(1, 0, 1, 0, 0, "z_idle");
    cyc(0, 0, 1, 0, 0, "z_idle2");
    cyc(1, 6, 1, 0, 0, "z_run_start");
    cyc(1, 0, 1, 0, 0, "z_run");
    cyc(0, 0, 1, 0, 0, "z_run2");

    // N=255: exactly 255 enabled cycles, no wrap
    cyc(1, 255, 1, 0, 0, "max_start");
    lat = 0;
    for (int i = 1; i <= 300 && lat == 0; i++) begin
      cyc(0, 0, 1, 0, 0, "max_run");
      if (bus.expire === 1'b1) lat = i;
    end
    chk("max_latency", 32'(lat), 32'd255);
    cyc(0, 0, 1, 0, 0, "max_after");

    // start and abort together in RUN
    cyc(1, 9, 1, 0, 0, "sa_start");
    cyc(1, 7, 1, 0, 1, "sa_both");
    cyc(0, 0, 1, 0, 0, "sa_after");

    // async reset at count=6 of 10, then N=2
    cyc(1, 10, 1, 0, 0, "rst_start");
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, "rst_run");
    chk("rst_at6", 32'(bus.count), 32'd6);
    areset("rst_mid");
    cyc(1, 2, 1, 0, 0, "rst_n2");
    lat = 0;
    for (int i = 1; i <= 5 && lat == 0; i++) begin
      cyc(0, 0, 1, 0, 0, "rst_n2run");
      if (bus.expire === 1'b1) lat = i;
    end
    chk("rst_n2_latency", 32'(lat), 32'd2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      st_r = ($urandom_range(0, 9) == 0);
      ab_r = ($urandom_range(0, 24) == 0);
      en_r = ($urandom_range(0, 3) != 0);
      rl_r = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) lv_r = $urandom_range(0, 255);
      else lv_r = $urandom_range(0, 4);
      cyc(st_r, lv_r, en_r, rl_r, ab_r, "rnd");
      if ($urandom_range(0, 199) == 0) areset("rnd_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
